ps2_key_event_fifo: RTL



---
 rtl/ps2_key_event_fifo.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_event_fifo.sv
// PS/2 keyboard front end: input synchronisers, 11-bit frame receiver with
// parity/stop/timeout checks, E0/F0 prefix folding into key events, and a
// first-word-fall-through event FIFO plus a scan-code LED register.
module ps2_key_event_fifo #(
  parameter int DEPTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int LED_MODE       = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  output logic [9:0]               evt_data,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               leds,
  output logic                     overflow,
  output logic                     err_parity,
  output logic                     err_frame,
  input  logic                     clear_errors
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s, w_dat_s, w_fall;

  state_t                 r_state, w_state_nxt;
  logic [7:0]             r_shift;
  logic [2:0]             r_bitcnt;
  logic                   r_par;
  logic [TW-1:0]          r_tmo;
  logic                   w_tmo_hit, w_stop_edge, w_par_ok, w_good;
  logic                   w_perr, w_ferr;

  logic                   r_byte_vld, r_byte_err;
  logic [7:0]             r_byte;
  logic                   r_ext, r_brk;
  logic                   w_push;

  logic [9:0]             r_mem [DEPTH];
  logic [AW-1:0]          r_wptr, r_rptr;
  logic [CW-1:0]          r_count;
  logic                   w_full, w_pop, w_wr, w_ovf;

  logic [7:0]             r_leds;
  logic                   r_overflow, r_err_parity, r_err_frame;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
  assign w_fall  = r_clk_prev & ~w_clk_s;

  // Bring the keyboard lines into the clk domain; idle level of the bus is 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev <= w_clk_s;
    end
  end

  assign w_tmo_hit   = (r_state != S_IDLE) && !w_fall &&
                       (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_stop_edge = w_fall && (r_state == S_STOP);
  assign w_par_ok    = ^{r_shift, r_par};
  assign w_good      = w_stop_edge && w_dat_s && w_par_ok;
  assign w_perr      = w_stop_edge && !w_par_ok;
  assign w_ferr      = (w_stop_edge && !w_dat_s) || w_tmo_hit;

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Receiver next state: advance on falling edges, bail out on timeout.
  always_comb begin
    w_state_nxt = r_state;
    if (w_tmo_hit) begin
      w_state_nxt = S_IDLE;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE:   if (!w_dat_s) w_state_nxt = S_DATA;
        S_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Receiver datapath: shift register, bit count, idle timer, byte handoff.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_par      <= 1'b0;
      r_tmo      <= '0;
      r_byte_vld <= 1'b0;
      r_byte_err <= 1'b0;
      r_byte     <= '0;
    end else begin
      r_byte_vld <= w_good;
      r_byte_err <= w_perr || w_ferr;
      if (w_good) r_byte <= r_shift;
      if (r_state == S_IDLE || w_fall) r_tmo <= '0;
      else                             r_tmo <= r_tmo + TW'(1);
      if (w_fall) begin
        case (r_state)
          S_IDLE:   r_bitcnt <= '0;
          S_DATA: begin
            r_shift  <= {w_dat_s, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
          end
          S_PARITY: r_par <= w_dat_s;
          default:  ;
        endcase
      end
    end
  end

  assign w_push = r_byte_vld && (r_byte != 8'hE0) && (r_byte != 8'hF0) &&
                  (r_byte != 8'h00) && (r_byte != 8'hFF);

  // Prefix flags: E0/F0 arm them, anything else (good or discarded) clears.
  always_ff @(posedge clk) begin
    if (reset || r_byte_err) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (r_byte_vld) begin
      if (r_byte == 8'hE0)      r_ext <= 1'b1;
      else if (r_byte == 8'hF0) r_brk <= 1'b1;
      else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  assign w_full    = (r_count == CW'(DEPTH));
  assign evt_valid = (r_count != '0);
  assign w_pop     = evt_valid && evt_ready;
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovf     = w_push && w_full && !w_pop;

  // Event storage; no reset needed since reads are gated by evt_valid.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= {r_brk, r_ext, r_byte};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  // LED display follows decoded events, including ones dropped on overflow.
  always_ff @(posedge clk) begin
    if (reset)
      r_leds <= '0;
    else if (w_push && (LED_MODE != 0 || !r_brk))
      r_leds <= r_byte;
  end

  // Sticky flags; a fresh error outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow   <= 1'b0;
      r_err_parity <= 1'b0;
      r_err_frame  <= 1'b0;
    end else begin
      r_overflow   <= w_ovf  | (r_overflow   & ~clear_errors);
      r_err_parity <= w_perr | (r_err_parity & ~clear_errors);
      r_err_frame  <= w_ferr | (r_err_frame  & ~clear_errors);
    end
  end

  assign evt_data   = evt_valid ? r_mem[r_rptr] : '0;
  assign fifo_count = r_count;
  assign leds       = r_leds;
  assign overflow   = r_overflow;
  assign err_parity = r_err_parity;
  assign err_frame  = r_err_frame;

endmodule
